// File: rtl/sram_slot_if.sv
// Bus bundle between the slot arbiter, its SRAM clients and the SRAM pin logic.
// slave = arbiter side, master = client/pin side.
interface sram_slot_if #(
    parameter int N_CLIENTS = 4,
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16
);
    logic                          i_start;
    logic [N_CLIENTS-1:0]          i_client_en;
    logic [N_CLIENTS*ADDR_W-1:0]   i_client_addr;
    logic [N_CLIENTS-1:0]          i_client_we_n;
    logic [N_CLIENTS*DATA_W-1:0]   i_client_wdata;
    logic [N_CLIENTS-1:0]          i_client_done;
    logic [N_CLIENTS-1:0]          o_grant;
    logic [DATA_W-1:0]             o_client_rdata;
    logic [ADDR_W-1:0]             o_sram_addr;
    logic                          o_sram_we_n;
    logic [DATA_W-1:0]             o_sram_wdata;
    logic                          o_sram_dq_oe;
    logic [DATA_W-1:0]             i_sram_dq;
    logic                          o_busy;
    logic                          o_frame_done;
    logic                          o_overrun;
    logic                          o_timeout;

    modport slave (
        input  i_start, i_client_en, i_client_addr, i_client_we_n, i_client_wdata,
               i_client_done, i_sram_dq,
        output o_grant, o_client_rdata, o_sram_addr, o_sram_we_n, o_sram_wdata,
               o_sram_dq_oe, o_busy, o_frame_done, o_overrun, o_timeout
    );

    modport master (
        output i_start, i_client_en, i_client_addr, i_client_we_n, i_client_wdata,
               i_client_done, i_sram_dq,
        input  o_grant, o_client_rdata, o_sram_addr, o_sram_we_n, o_sram_wdata,
               o_sram_dq_oe, o_busy, o_frame_done, o_overrun, o_timeout
    );
endinterface

// File: rtl/sram_slot_arbiter.sv
// Per-sample time-slot arbiter for the shared async SRAM: grants enabled clients in ascending order.
// Define SRAM_SLOT_TIMEOUT_EN to force a handover after TIMEOUT_CYC granted cycles without done.
module sram_slot_arbiter #(
    parameter int N_CLIENTS   = 4,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input logic          i_AUD_BCLK,
    input logic          i_rst_n,
    sram_slot_if.slave   io_bus
);
    localparam int CUR_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    if (N_CLIENTS < 1 || N_CLIENTS > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("sram_slot_arbiter: parameter out of range");
    end

    typedef enum logic {S_IDLE = 1'b0, S_SLOT = 1'b1} state_t;

    state_t                 r_state, w_state_n;
    logic [CUR_W-1:0]       r_cur, w_cur_n;
    logic [N_CLIENTS-1:0]   r_mask, w_mask_n;
    logic [N_CLIENTS-1:0]   r_grant, w_grant_n;
    logic                   r_frame_done, r_overrun, r_timeout;
    logic                   w_fd_n, w_ov_n, w_to_n;
    logic                   w_has_first, w_has_next, w_done_cur, w_tmo;
    logic [CUR_W-1:0]       w_first_idx, w_next_idx;
    logic [N_CLIENTS-1:0]   w_cur_oh, w_above;

    // Lowest set bit: {found, index}
    function automatic logic [CUR_W:0] f_lowest(input logic [N_CLIENTS-1:0] v);
        logic [CUR_W:0] res;
        res = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--)
            if (v[i]) res = {1'b1, CUR_W'(i)};
        return res;
    endfunction

    assign {w_has_first, w_first_idx} = f_lowest(io_bus.i_client_en);
    assign w_cur_oh   = N_CLIENTS'(1) << r_cur;
    assign w_above    = r_mask & ~(w_cur_oh | (w_cur_oh - N_CLIENTS'(1)));
    assign {w_has_next, w_next_idx} = f_lowest(w_above);
    assign w_done_cur = io_bus.i_client_done[r_cur];

`ifdef SRAM_SLOT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_clr;

    // Counter reads 0 on the first granted cycle of every slot
    assign w_tmo     = (r_state == S_SLOT) && !w_done_cur && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign w_cnt_clr = (r_state != S_SLOT) || w_done_cur || w_tmo;

    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n)       r_cnt <= '0;
        else if (w_cnt_clr) r_cnt <= '0;
        else                r_cnt <= r_cnt + 1'b1;
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_state_n = r_state;
        w_cur_n   = r_cur;
        w_mask_n  = r_mask;
        w_fd_n    = 1'b0;
        w_ov_n    = 1'b0;
        w_to_n    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.i_start) begin
                    w_mask_n = io_bus.i_client_en;
                    if (w_has_first) begin
                        w_state_n = S_SLOT;
                        w_cur_n   = w_first_idx;
                    end else begin
                        w_fd_n = 1'b1;
                    end
                end
            end
            S_SLOT: begin
                w_ov_n = io_bus.i_start;
                if (w_done_cur || w_tmo) begin
                    w_to_n = w_tmo;
                    if (w_has_next) begin
                        w_cur_n = w_next_idx;
                    end else begin
                        w_state_n = S_IDLE;
                        w_fd_n    = 1'b1;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
        w_grant_n = (w_state_n == S_SLOT) ? (N_CLIENTS'(1) << w_cur_n) : '0;
    end

    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cur        <= '0;
            r_mask       <= '0;
            r_grant      <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_cur        <= w_cur_n;
            r_mask       <= w_mask_n;
            r_grant      <= w_grant_n;
            r_frame_done <= w_fd_n;
            r_overrun    <= w_ov_n;
            r_timeout    <= w_to_n;
        end
    end

    // SRAM mux; DQ is only driven while the granted client writes
    logic [ADDR_W-1:0] w_sram_addr;
    logic              w_sram_we_n;
    logic [DATA_W-1:0] w_sram_wdata;

    always_comb begin
        w_sram_addr  = '0;
        w_sram_we_n  = 1'b1;
        w_sram_wdata = '0;
        if (r_state == S_SLOT) begin
            w_sram_addr = io_bus.i_client_addr[int'(r_cur)*ADDR_W +: ADDR_W];
            w_sram_we_n = io_bus.i_client_we_n[r_cur];
            if (!w_sram_we_n)
                w_sram_wdata = io_bus.i_client_wdata[int'(r_cur)*DATA_W +: DATA_W];
        end
    end

    assign io_bus.o_grant        = r_grant;
    assign io_bus.o_busy         = (r_state == S_SLOT);
    assign io_bus.o_frame_done   = r_frame_done;
    assign io_bus.o_overrun      = r_overrun;
    assign io_bus.o_timeout      = r_timeout;
    assign io_bus.o_sram_addr    = w_sram_addr;
    assign io_bus.o_sram_we_n    = w_sram_we_n;
    assign io_bus.o_sram_wdata   = w_sram_wdata;
    assign io_bus.o_sram_dq_oe   = ~w_sram_we_n;
    assign io_bus.o_client_rdata = io_bus.i_sram_dq;
endmodule

// File: tb/tb_sram_slot_arbiter.sv
// Bench for sram_slot_arbiter: directed cycle tables, corner sequences, and random traffic vs a queue model.
module tb_sram_slot_arbiter;
    localparam int N  = 3;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_slot_if #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_slot_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .i_AUD_BCLK (clk),
        .i_rst_n    (rst_n),
        .io_bus     (bus)
    );

    logic [N-1:0][AW-1:0] t_addr;
    logic [N-1:0][DW-1:0] t_wd;
    logic [N-1:0]         t_we;
    assign bus.i_client_addr  = t_addr;
    assign bus.i_client_wdata = t_wd;
    assign bus.i_client_we_n  = t_we;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic         start;
        logic [N-1:0] en, done, we;
        logic [N-1:0] e_grant;
        logic         e_busy, e_fd, e_ov, e_we, e_oe;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic s, logic [N-1:0] en, logic [N-1:0] dn, logic [N-1:0] we,
                                logic [N-1:0] gr, logic b, logic fd, logic ov, logic swe, logic oe);
        vec_t v;
        v.start = s; v.en = en; v.done = dn; v.we = we;
        v.e_grant = gr; v.e_busy = b; v.e_fd = fd; v.e_ov = ov; v.e_we = swe; v.e_oe = oe;
        return v;
    endfunction

    // Reference model: the frame is a queue of enabled indices, front = granted client
    int q[$];
    int m_cnt;
    logic m_fd, m_ov, m_to;

    task automatic model_step();
        logic fin;
        m_fd = 1'b0; m_ov = 1'b0; m_to = 1'b0;
        if (q.size() == 0) begin
            if (bus.i_start) begin
                for (int c = 0; c < N; c++) if (bus.i_client_en[c]) q.push_back(c);
                m_cnt = 0;
                if (q.size() == 0) m_fd = 1'b1;
            end
        end else begin
            if (bus.i_start) m_ov = 1'b1;
            fin = bus.i_client_done[q[0]];
`ifdef SRAM_SLOT_TIMEOUT_EN
            if (!fin && m_cnt == TO - 1) begin fin = 1'b1; m_to = 1'b1; end
`endif
            if (fin) begin
                void'(q.pop_front());
                m_cnt = 0;
                if (q.size() == 0) m_fd = 1'b1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    function automatic logic [63:0] model_out();
        logic [N-1:0] gr;
        logic [AW-1:0] a;
        logic we, oe;
        logic [DW-1:0] wd;
        gr = '0; a = '0; we = 1'b1; wd = '0;
        if (q.size() != 0) begin
            gr[q[0]] = 1'b1;
            a  = t_addr[q[0]];
            we = t_we[q[0]];
            if (!we) wd = t_wd[q[0]];
        end
        oe = !we;
        return {3'b0, gr, (q.size() != 0), m_fd, m_ov, m_to, a, we, wd, oe, bus.i_sram_dq};
    endfunction

    function automatic logic [63:0] dut_out();
        return {3'b0, bus.o_grant, bus.o_busy, bus.o_frame_done, bus.o_overrun, bus.o_timeout,
                bus.o_sram_addr, bus.o_sram_we_n, bus.o_sram_wdata, bus.o_sram_dq_oe, bus.o_client_rdata};
    endfunction

    task automatic idle_inputs();
        bus.i_start = 1'b0; bus.i_client_en = '0; bus.i_client_done = '0;
        t_we = '1; bus.i_sram_dq = '0;
    endtask

    initial begin
        idle_inputs();
        t_addr = '0; t_wd = '0;
        #3;
        chk("reset state", {bus.o_grant, bus.o_busy, bus.o_frame_done, bus.o_overrun, bus.o_timeout,
                            bus.o_sram_addr, bus.o_sram_we_n, bus.o_sram_wdata, bus.o_sram_dq_oe},
            {3'b000, 4'b0000, 20'h0, 1'b1, 16'h0, 1'b0});
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // full frame, skip mask, empty frame, overrun / back-to-back
        tbl.push_back(mk(1, 3'b111, 3'b000, 3'b111, 3'b000, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3'b000, 3'b000, 3'b111, 3'b001, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3'b000, 3'b000, 3'b111, 3'b001, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3'b000, 3'b001, 3'b111, 3'b001, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3'b000, 3'b000, 3'b101, 3'b010, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 3'b000, 3'b010, 3'b111, 3'b010, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3'b000, 3'b100, 3'b111, 3'b100, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3'b000, 3'b000, 3'b111, 3'b000, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3'b101, 3'b000, 3'b111, 3'b000, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3'b101, 3'b010, 3'b111, 3'b001, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3'b101, 3'b001, 3'b111, 3'b001, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3'b101, 3'b100, 3'b111, 3'b100, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3'b101, 3'b000, 3'b111, 3'b000, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3'b011, 3'b000, 3'b111, 3'b000, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3'b100, 3'b000, 3'b111, 3'b001, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3'b100, 3'b001, 3'b111, 3'b001, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 3'b001, 3'b010, 3'b111, 3'b010, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3'b001, 3'b000, 3'b111, 3'b000, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 3'b000, 3'b000, 3'b111, 3'b001, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3'b000, 3'b001, 3'b111, 3'b001, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3'b000, 3'b000, 3'b111, 3'b000, 0, 1, 0, 1, 0));

        foreach (tbl[i]) begin
            bus.i_start = tbl[i].start; bus.i_client_en = tbl[i].en;
            bus.i_client_done = tbl[i].done; t_we = tbl[i].we;
            #1;
            chk($sformatf("table row %0d", i),
                {bus.o_grant, bus.o_busy, bus.o_frame_done, bus.o_overrun, bus.o_sram_we_n, bus.o_sram_dq_oe},
                {tbl[i].e_grant, tbl[i].e_busy, tbl[i].e_fd, tbl[i].e_ov, tbl[i].e_we, tbl[i].e_oe});
            @(posedge clk); #1;
        end
        idle_inputs();

        // SRAM data path while client 1 holds the slot
        bus.i_start = 1'b1; bus.i_client_en = 3'b010;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        t_addr[0] = 20'hAAAAA; t_addr[1] = 20'h12345; t_addr[2] = 20'h55555;
        t_wd[0] = 16'h1111; t_wd[1] = 16'hBEEF; t_wd[2] = 16'h2222;
        t_we = 3'b101;
        #1;
        chk("write addr", bus.o_sram_addr, 20'h12345);
        chk("write oe/we", {bus.o_sram_dq_oe, bus.o_sram_we_n}, 2'b10);
        chk("write data", bus.o_sram_wdata, 16'hBEEF);
        t_we = 3'b111; bus.i_sram_dq = 16'h1234;
        #1;
        chk("read oe", bus.o_sram_dq_oe, 1'b0);
        chk("read wdata zero", bus.o_sram_wdata, 16'h0);
        chk("read rdata", bus.o_client_rdata, 16'h1234);
        bus.i_client_done = 3'b010;
        @(posedge clk); #1;
        chk("single client frame_done", {bus.o_frame_done, bus.o_grant}, {1'b1, 3'b000});
        idle_inputs();

`ifdef SRAM_SLOT_TIMEOUT_EN
        // silent client 0 is cut off after TO granted cycles
        bus.i_start = 1'b1; bus.i_client_en = 3'b011;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        for (int k = 0; k < TO; k++) begin
            #1;
            chk($sformatf("timeout hold %0d", k), {bus.o_grant, bus.o_timeout}, {3'b001, 1'b0});
            @(posedge clk); #1;
        end
        chk("timeout handover", {bus.o_grant, bus.o_timeout}, {3'b010, 1'b1});
        bus.i_client_done = 3'b010;
        @(posedge clk); #1;
        chk("timeout frame end", {bus.o_frame_done, bus.o_timeout}, 2'b10);
        idle_inputs();
        // done on the last allowed cycle is an ordinary done
        bus.i_start = 1'b1; bus.i_client_en = 3'b011;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (TO - 1) @(posedge clk);
        #1;
        bus.i_client_done = 3'b001;
        @(posedge clk); #1;
        chk("late done no timeout", {bus.o_grant, bus.o_timeout}, {3'b010, 1'b0});
        bus.i_client_done = 3'b010;
        @(posedge clk); #1;
        idle_inputs();
`endif

        // async reset in the middle of a write slot
        bus.i_start = 1'b1; bus.i_client_en = 3'b001;
        @(posedge clk); #1;
        bus.i_start = 1'b0; t_we = 3'b110;
        #1;
        chk("pre-reset grant", {bus.o_grant, bus.o_sram_dq_oe}, {3'b001, 1'b1});
        #1 rst_n = 1'b0;
        #1;
        chk("async reset", {bus.o_grant, bus.o_busy, bus.o_sram_addr, bus.o_sram_we_n, bus.o_sram_dq_oe},
            {3'b000, 1'b0, 20'h0, 1'b1, 1'b0});
        idle_inputs();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // random traffic against the queue model
        q.delete(); m_cnt = 0; m_fd = 1'b0; m_ov = 1'b0; m_to = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.i_start = ($urandom_range(0, 5) == 0);
            bus.i_client_en = N'($urandom);
            for (int c = 0; c < N; c++) begin
                bus.i_client_done[c] = ($urandom_range(0, 3) == 0);
                t_addr[c] = AW'($urandom);
                t_wd[c]   = DW'($urandom);
            end
            t_we = N'($urandom);
            bus.i_sram_dq = DW'($urandom);
            #1;
            chk($sformatf("random cycle %0d", cyc), dut_out(), model_out());
            @(posedge clk);
            model_step();
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
